// File: rtl/weight_bram_pkg.sv
// Shared constants and FSM encoding for the weight BRAM fill and read controllers.
package weight_bram_pkg;

  localparam int NUM_BANKS = 16;
  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 16;
  localparam int BANK_W    = $clog2(NUM_BANKS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } load_state_t;

endpackage

// File: rtl/weight_bram_loader_if.sv
// Weight stream input plus the shared bank write bus driven by the loader.
interface weight_bram_loader_if #(
  parameter int NUM_BANKS = weight_bram_pkg::NUM_BANKS,
  parameter int ADDR_W    = weight_bram_pkg::ADDR_W,
  parameter int DATA_W    = weight_bram_pkg::DATA_W
) ();

  logic                 s_valid;
  logic [DATA_W-1:0]    s_data;
  logic                 s_ready;
  logic [NUM_BANKS-1:0] w_we;
  logic [ADDR_W-1:0]    w_addr_wr;
  logic [DATA_W-1:0]    w_din;

  modport master (
    output s_valid, s_data,
    input  s_ready, w_we, w_addr_wr, w_din
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, w_we, w_addr_wr, w_din
  );

endinterface

// File: rtl/weight_bram_loader_bank_row_counter.sv
// Bank-major, row-minor position counter over an inclusive row window.
module bank_row_counter #(
  parameter int NUM_BANKS = 16,
  parameter int ADDR_W    = 9,
  parameter int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] row_start,
  input  logic [ADDR_W-1:0] row_end,
  output logic [BANK_W-1:0] bank,
  output logic [ADDR_W-1:0] row,
  output logic              last
);

  logic [ADDR_W-1:0] end_q;
  logic              last_bank;

  assign last_bank = (bank == BANK_W'(NUM_BANKS - 1));
  assign last      = last_bank && (row == end_q);

  // Row advance is suppressed at the window end so a full 0..511 window never wraps to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank  <= '0;
      row   <= '0;
      end_q <= '0;
    end else if (load) begin
      bank  <= '0;
      row   <= row_start;
      end_q <= row_end;
    end else if (inc) begin
      if (last_bank) begin
        bank <= '0;
        if (row != end_q) begin
          row <= row + 1'b1;
        end
      end else begin
        bank <= bank + 1'b1;
      end
    end
  end

endmodule

// File: rtl/weight_bram_loader.sv
// Fills the banked weight BRAM round-robin from a valid/ready stream, then pulses done.
module weight_bram_loader #(
  parameter int NUM_BANKS = weight_bram_pkg::NUM_BANKS,
  parameter int ADDR_W    = weight_bram_pkg::ADDR_W,
  parameter int DATA_W    = weight_bram_pkg::DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    addr_start,
  input  logic [ADDR_W-1:0]    addr_end,
  weight_bram_loader_if.slave  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  import weight_bram_pkg::*;

  localparam int BW = $clog2(NUM_BANKS);

  load_state_t          state_q, state_d;
  logic                 err_q;
  logic                 window_bad;
  logic                 cnt_load;
  logic                 hs;
  logic [BW-1:0]        bank;
  logic [ADDR_W-1:0]    row;
  logic                 cnt_last;
  logic [NUM_BANKS-1:0] w_we_q;
  logic [ADDR_W-1:0]    w_addr_q;
  logic [DATA_W-1:0]    w_din_q;
  logic                 s_ready_c, busy_c, done_c, err_c;

  assign window_bad = (addr_end < addr_start);
  assign cnt_load   = (state_q == IDLE) && start;
  assign hs         = (state_q == LOAD) && bus.s_valid;

  bank_row_counter #(
    .NUM_BANKS (NUM_BANKS),
    .ADDR_W    (ADDR_W),
    .BANK_W    (BW)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .inc       (hs),
    .row_start (addr_start),
    .row_end   (addr_end),
    .bank      (bank),
    .row       (row),
    .last      (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    s_ready_c = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    err_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = window_bad ? DONE : LOAD;
        end
      end
      LOAD: begin
        s_ready_c = 1'b1;
        busy_c    = 1'b1;
        if (hs && cnt_last) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        busy_c  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        busy_c  = 1'b1;
        done_c  = 1'b1;
        err_c   = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset has priority over a write handshake in the same cycle, so that write is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      err_q    <= 1'b0;
      w_we_q   <= '0;
      w_addr_q <= '0;
      w_din_q  <= '0;
    end else begin
      state_q <= state_d;
      if (cnt_load) begin
        err_q <= window_bad;
      end
      w_we_q <= hs ? ({{(NUM_BANKS-1){1'b0}}, 1'b1} << bank) : '0;
      if (hs) begin
        w_addr_q <= row;
        w_din_q  <= bus.s_data;
      end
    end
  end

  assign bus.s_ready   = s_ready_c;
  assign bus.w_we      = w_we_q;
  assign bus.w_addr_wr = w_addr_q;
  assign bus.w_din     = w_din_q;
  assign busy          = busy_c;
  assign done          = done_c;
  assign err           = err_c;

endmodule

// File: tb/tb_weight_bram_loader.sv
// Randomized scoreboard bench for weight_bram_loader against a word-index reference model.
module tb_weight_bram_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] addr_start;
  logic [8:0] addr_end;
  logic       busy, done, err;

  weight_bram_loader_if bus ();

  always #5 clk = ~clk;

  weight_bram_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .addr_start (addr_start),
    .addr_end   (addr_end),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  typedef struct { int bank; int addr; int data; int cyc; } wr_t;
  typedef struct { int cyc; int err; } dn_t;

  wr_t wr_q[$];
  dn_t dn_q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  last_bank = -1;
  int  last_addr = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    tests++;
    fails++;
    $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every presented write or done pulse is matched against the scoreboard queues.
  always @(negedge clk) begin
    wr_t         e;
    dn_t         d;
    logic [15:0] oh;
    if (bus.w_we != 16'd0) begin
      if (wr_q.size() == 0) begin
        fail_now("unexpected_write_we", int'(bus.w_we), 0);
      end else begin
        e  = wr_q.pop_front();
        oh = 16'd1 << e.bank;
        check("w_we", int'(bus.w_we), int'(oh));
        check("w_addr_wr", int'(bus.w_addr_wr), e.addr);
        check("w_din", int'(bus.w_din), e.data);
        check("write_cycle", cyc, e.cyc);
        last_bank = e.bank;
        last_addr = int'(bus.w_addr_wr);
      end
    end
    if (done) begin
      if (dn_q.size() == 0) begin
        fail_now("unexpected_done", 1, 0);
      end else begin
        d = dn_q.pop_front();
        check("done_cycle", cyc, d.cyc);
        check("err_with_done", int'(err), d.err);
        check("busy_with_done", int'(busy), 1);
      end
    end else if (err) begin
      fail_now("err_without_done", 1, 0);
    end
  end

  task automatic wait_done();
    int t = 0;
    while (dn_q.size() != 0 && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (dn_q.size() != 0) begin
      fail_now("done_timeout_pending", dn_q.size(), 0);
      dn_q.delete();
    end
    check("pending_writes", wr_q.size(), 0);
    wr_q.delete();
  endtask

  // vmode: 0 valid always, 1 valid every third cycle, 2 random valid; dmode: 0 counting, 1 random data.
  task automatic applyStimulus(input int as, input int ae, input int vmode, input int dmode,
                               input int busy_idx, input int abort_after);
    int   words, n, i, c;
    bit   pulsed;
    @(posedge clk); #1;
    start      = 1'b1;
    addr_start = 9'(as);
    addr_end   = 9'(ae);
    c          = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    if (ae < as) begin
      dn_q.push_back('{c + 1, 1});
      bus.s_valid = 1'b1;
      repeat (4) begin
        @(negedge clk);
        check("s_ready_err_path", int'(bus.s_ready), 0);
        @(posedge clk); #1;
      end
      bus.s_valid = 1'b0;
      wait_done();
      return;
    end
    check("s_ready_after_start", int'(bus.s_ready), 1);
    words  = 16 * (ae - as + 1);
    n      = 0;
    i      = 0;
    pulsed = 1'b0;
    while (n < words) begin
      if (i > words * 6 + 50) begin
        fail_now("handshake_timeout_words", n, words);
        break;
      end
      if (abort_after > 0 && n == abort_after) begin
        rst         = 1'b1;
        bus.s_valid = 1'b1;
        @(posedge clk); #1;
        check("rst_w_we", int'(bus.w_we), 0);
        check("rst_s_ready", int'(bus.s_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst         = 1'b0;
        bus.s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pending_writes_after_rst", wr_q.size(), 0);
        return;
      end
      case (vmode)
        0:       bus.s_valid = 1'b1;
        1:       bus.s_valid = (i % 3 == 0);
        default: bus.s_valid = ($urandom_range(0, 3) != 0);
      endcase
      bus.s_data = (dmode != 0) ? 16'($urandom) : 16'(n);
      if (busy_idx >= 0 && n == busy_idx && !pulsed) begin
        start      = 1'b1;
        addr_start = 9'(as + 5);
        addr_end   = 9'(as);
        pulsed     = 1'b1;
      end
      @(negedge clk);
      if (bus.s_valid && bus.s_ready) begin
        wr_q.push_back('{n % 16, as + n / 16, int'(bus.s_data), cyc + 1});
        n++;
        if (n == words) begin
          dn_q.push_back('{cyc + 2, 0});
        end
      end
      @(posedge clk); #1;
      start = 1'b0;
      i++;
    end
    bus.s_valid = 1'b0;
    wait_done();
  endtask

  task automatic checkOutput();
    check("reset_s_ready", int'(bus.s_ready), 0);
    check("reset_w_we", int'(bus.w_we), 0);
    check("reset_w_addr_wr", int'(bus.w_addr_wr), 0);
    check("reset_w_din", int'(bus.w_din), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_err", int'(err), 0);
  endtask

  initial begin
    int as, ae;
    rst         = 1'b1;
    start       = 1'b0;
    addr_start  = '0;
    addr_end    = '0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;

    applyStimulus(128, 255, 0, 0, -1, 0);
    applyStimulus(10, 10, 1, 0, -1, 0);
    applyStimulus(20, 19, 0, 0, -1, 0);
    applyStimulus(0, 511, 2, 1, -1, 0);
    check("full_range_last_bank", last_bank, 15);
    check("full_range_last_addr", last_addr, 511);
    applyStimulus(100, 140, 0, 1, -1, 37);
    applyStimulus(0, 0, 0, 0, -1, 0);
    applyStimulus(50, 52, 2, 1, 20, 0);
    for (int k = 0; k < 3; k++) begin
      as = int'($urandom_range(0, 508));
      ae = as + int'($urandom_range(0, 3));
      applyStimulus(as, ae, 2, 1, -1, 0);
    end

    repeat (4) @(posedge clk);
    #1;
    check("final_pending_writes", wr_q.size(), 0);
    check("final_pending_done", dn_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/weight_bram_loader.md
# weight_bram_loader

Upstream fill stage for the 16-bank transpose-convolution weight BRAM. Accepts a valid/ready stream of 16-bit weights and writes them round-robin across the 16 banks over an address window `addr_start..addr_end`. It pulses `done` when the window is full, and that pulse starts the weight read controller. One write per cycle maximum, and only one bank written per cycle.

## Interface
Parameters:
- `NUM_BANKS`, 16, number of weight BRAM banks
- `ADDR_W`, 9, BRAM address width
- `DATA_W`, 16, weight word width

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle load request, sampled in IDLE only
- `addr_start`  in  ADDR_W  first row address, latched at start
- `addr_end`  in  ADDR_W  last row address (inclusive), latched at start
- `s_valid`  in  1  weight word valid
- `s_data`  in  DATA_W  weight word
- `s_ready`  out  1  loader accepts a word this cycle
- `w_we`  out  NUM_BANKS  one-hot bank write enable, registered
- `w_addr_wr`  out  ADDR_W  write address shared by all banks, registered
- `w_din`  out  DATA_W  write data shared by all banks, registered
- `busy`  out  1  high from LOAD entry through the DONE cycle
- `done`  out  1  one-cycle pulse when the load ends
- `err`  out  1  one-cycle pulse with `done` when `addr_end < addr_start`

## Operation
- FSM states: IDLE, LOAD, FLUSH, DONE.
- **IDLE**
  - On `start`, latch the window. Set `bank_idx=0` and `cur_addr=addr_start`.
  - If `addr_end < addr_start`, go to DONE with `err` set and perform no writes. Otherwise go to LOAD.
  - `start` is ignored in every other state.
- **LOAD**
  - `s_ready=1`.
  - On handshake (`s_valid & s_ready`), the next cycle has:
    - `w_we = 1<<bank_idx`
    - `w_addr_wr = cur_addr`
    - `w_din = s_data`
  - After the handshake, `bank_idx` increments. When `bank_idx` wraps from 15 to 0, `cur_addr` increments.
  - On the handshake with `bank_idx==15` and `cur_addr==addr_end`, go to FLUSH.
- **FLUSH**
  - `s_ready=0`.
  - The final registered write is on the outputs this cycle. Go to DONE.
- **DONE**
  - `done=1` and `busy=1` for exactly one cycle. Return to IDLE.
- Word count per load is `NUM_BANKS*(addr_end-addr_start+1)`, maximum 8192. Bank sequence: row `addr_start` banks 0..15, then row `addr_start+1`, and so on.
- `cur_addr` never exceeds `addr_end`. A window of `0..511` does not wrap, because the final increment is suppressed.
- `w_addr_wr` and `w_din` hold their last value when `w_we==0`. Downstream treats them as don't-care then.

## Timing
- Reset values: `s_ready=0`, `w_we=0`, `w_addr_wr=0`, `w_din=0`, `busy=0`, `done=0`, `err=0`. FSM in IDLE.
- `start` high at cycle 0 → LOAD and `s_ready=1` in cycle 1.
- Handshake at cycle k → write visible at cycle k+1. Latency is 1 cycle.
- Last handshake at cycle k → FLUSH with the final write at k+1, `done` at k+2, IDLE at k+3. A new `start` is accepted at k+3.
- Error path: `start` at cycle 0 → `done=err=1` in cycle 1, no `w_we`.
- Stalls: `s_valid=0` in LOAD produces no write. Bank and address counters hold. There is no timeout.
- `s_ready` is a function of state only. It does not depend on `s_valid`.
- `rst` during any state:
  - Next cycle returns to reset values.
  - No `done` is pulsed.
  - A write registered in the reset cycle is dropped (`w_we=0`).
- `start` together with `rst` is ignored.

## Structure
- Shared package `weight_bram_pkg`:
  - `NUM_BANKS`, `ADDR_W`, `DATA_W`, shared with the read controller.
  - FSM state encoding (2 bits).
- Optional sub-module `bank_row_counter`:
  - 4-bit bank index plus ADDR_W row address.
  - Inputs: `load`, `inc`.
  - Outputs: `last` (`bank==15 && row==end`).
  - Reusable by the read-side controller.
- No other hierarchy.

## Test plan
- Nominal fill:
  - Stimulus: window 128..255, `s_valid` held high, `s_data` = 0,1,2,…
  - Required: 2048 writes. Word n goes to bank n%16 at address 128+n/16. `done` pulses once, 2 cycles after the 2048th handshake.
- Backpressure:
  - Stimulus: window 10..10, `s_valid` toggling 1,0,0,1…
  - Required: 16 writes only on handshake+1, banks 0..15 at address 10, data order preserved.
- Error:
  - Stimulus: `addr_start=20`, `addr_end=19`.
  - Required: `done`&`err` in cycle 1, `w_we` never asserted, `s_ready` never high.
- Full range:
  - Stimulus: window 0..511.
  - Required: last write is bank 15 at address 511, no write to address 0 after the start row, `done` pulses.
- Reset mid-load:
  - Stimulus: assert `rst` after 37 handshakes.
  - Required: next cycle `w_we=0`, `s_ready=0`, `busy=0`, no `done`. A following load on window 0..0 completes normally with 16 writes.
- Start while busy:
  - Stimulus: pulse `start` with a different window during LOAD.
  - Required: ignored, and the original window completes unchanged.
